// File: rtl/pinball_pkg.sv
// Shared types and constants for the pinball ball-launch path.
package pinball_pkg;

    localparam int LIFE_W        = 4;
    localparam int DEF_INIT_LIFE = 3;
    localparam int DEF_MAX_LIFE  = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARK,
        ST_CHARGE,
        ST_FIRE,
        ST_FLIGHT,
        ST_RESPAWN,
        ST_OVER
    } state_t;

    // Add one life, clamped at the ceiling.
    function automatic logic [LIFE_W-1:0] life_inc_sat(
        input logic [LIFE_W-1:0] cur,
        input logic [LIFE_W-1:0] ceil
    );
        return (cur >= ceil) ? ceil : cur + 1'b1;
    endfunction

endpackage

// File: rtl/launch_charger.sv
// Saturating launch-speed accumulator: clear loads the starting speed,
// step adds one increment clamped at the maximum, otherwise hold.
module launch_charger #(
    parameter int SPEED_W    = 8,
    parameter int MIN_SPEED  = 16,
    parameter int MAX_SPEED  = 200,
    parameter int SPEED_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               step,
    output logic [SPEED_W-1:0] speed
);

    localparam logic [SPEED_W:0]   STEP_EXT = (SPEED_W+1)'(SPEED_STEP);
    localparam logic [SPEED_W:0]   MAX_EXT  = (SPEED_W+1)'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] MIN_VAL  = SPEED_W'(MIN_SPEED);
    localparam logic [SPEED_W-1:0] MAX_VAL  = SPEED_W'(MAX_SPEED);

    logic [SPEED_W:0]   sum;
    logic [SPEED_W-1:0] stepped;

    // One extra bit on the add so the clamp sees the true sum, never a wrap.
    always_comb begin
        sum     = {1'b0, speed} + STEP_EXT;
        stepped = (sum > MAX_EXT) ? MAX_VAL : sum[SPEED_W-1:0];
    end

    // Speed register: clear has priority over step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed <= '0;
        end else if (clear) begin
            speed <= MIN_VAL;
        end else if (step) begin
            speed <= stepped;
        end
    end

endmodule

// File: rtl/ball_launch_controller.sv
// Ball lifecycle sequencer: park, charge, fire, flight, loss, respawn.
// Optional feature macro: BONUS_LIFE_EN (bonusLife pulses add a life).
module ball_launch_controller
    import pinball_pkg::*;
#(
    parameter int INIT_LIFE      = DEF_INIT_LIFE,
    parameter int MAX_LIFE       = DEF_MAX_LIFE,
    parameter int SPEED_W        = 8,
    parameter int MIN_SPEED      = 16,
    parameter int MAX_SPEED      = 200,
    parameter int SPEED_STEP     = 4,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               startOfFrame,
    input  logic               key2IsPressed,
    input  logic               ballLost,
    input  logic               bonusLife,
    output logic [LIFE_W-1:0]  life,
    output logic               ballReady,
    output logic               ballActive,
    output logic               launch,
    output logic [SPEED_W-1:0] launchSpeed
);

    localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);
    localparam logic [LIFE_W-1:0] INIT_L     = LIFE_W'(INIT_LIFE);
    localparam logic [LIFE_W-1:0] MAX_L      = LIFE_W'(MAX_LIFE);
    localparam logic [CNT_W-1:0]  RESPAWN_L  = CNT_W'(RESPAWN_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    state_t            state;
    state_t            nxt;
    logic [CNT_W-1:0]  cnt;
    logic              bonus_ok;
    logic [LIFE_W-1:0] life_bonus;
    logic [LIFE_W-1:0] life_net;
    logic              charge_clear;
    logic              charge_step;

`ifndef BONUS_LIFE_EN
    logic unused_bonus;
    assign unused_bonus = bonusLife;
`endif

    // Life arithmetic: bonus saturates first, a loss then subtracts from that.
    always_comb begin
`ifdef BONUS_LIFE_EN
        bonus_ok = bonusLife && (state inside {ST_PARK, ST_CHARGE, ST_FIRE,
                                               ST_FLIGHT, ST_RESPAWN});
`else
        bonus_ok = 1'b0;
`endif
        life_bonus = bonus_ok ? life_inc_sat(life, MAX_L) : life;
        life_net   = life_bonus - 1'b1;
    end

    // Next-state decode; start low aborts to IDLE ahead of everything else.
    always_comb begin
        nxt = state;
        if (!start) begin
            nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:    nxt = ST_PARK;
                ST_PARK:    nxt = key2IsPressed ? ST_CHARGE : ST_PARK;
                ST_CHARGE:  nxt = key2IsPressed ? ST_CHARGE : ST_FIRE;
                ST_FIRE:    nxt = ST_FLIGHT;
                ST_FLIGHT:  if (ballLost) nxt = (life_net == '0) ? ST_OVER : ST_RESPAWN;
                ST_RESPAWN: if (startOfFrame && cnt == CNT_ONE) nxt = ST_PARK;
                ST_OVER:    nxt = ST_OVER;
                default:    nxt = ST_IDLE;
            endcase
        end
    end

    // Charger controls; a release in the same cycle as a frame does not step.
    always_comb begin
        charge_clear = start && (state == ST_PARK) && key2IsPressed;
        charge_step  = start && (state == ST_CHARGE) && key2IsPressed && startOfFrame;
    end

    launch_charger #(
        .SPEED_W    (SPEED_W),
        .MIN_SPEED  (MIN_SPEED),
        .MAX_SPEED  (MAX_SPEED),
        .SPEED_STEP (SPEED_STEP)
    ) u_charger (
        .clk   (clk),
        .reset (reset),
        .clear (charge_clear),
        .step  (charge_step),
        .speed (launchSpeed)
    );

    // State, life, respawn counter and the registered status flags.
    // Flags are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            life       <= INIT_L;
            cnt        <= '0;
            ballReady  <= 1'b0;
            ballActive <= 1'b0;
        end else begin
            state      <= nxt;
            ballReady  <= (nxt == ST_PARK) || (nxt == ST_CHARGE);
            ballActive <= (nxt == ST_FLIGHT);

            if (!start || state == ST_IDLE) begin
                life <= INIT_L;
            end else if (state == ST_FLIGHT && ballLost) begin
                life <= life_net;
            end else begin
                life <= life_bonus;
            end

            if (start && state == ST_FLIGHT && ballLost) begin
                cnt <= RESPAWN_L;
            end else if (start && state == ST_RESPAWN && startOfFrame) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Launch is a pure decode of the FIRE state.
    assign launch = (state == ST_FIRE);

endmodule

// File: tb/tb_ball_launch_controller.sv
// Self-checking bench for ball_launch_controller (honours BONUS_LIFE_EN).
module tb_ball_launch_controller;

    localparam int INIT_LIFE  = 3;
    localparam int MAX_LIFE   = 9;
    localparam int MIN_SPEED  = 16;
    localparam int MAX_SPEED  = 200;
    localparam int SPEED_STEP = 4;
    localparam int RESPAWN    = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       startOfFrame;
    logic       key2IsPressed;
    logic       ballLost;
    logic       bonusLife;
    logic [3:0] life;
    logic       ballReady;
    logic       ballActive;
    logic       launch;
    logic [7:0] launchSpeed;

    ball_launch_controller #(
        .INIT_LIFE      (INIT_LIFE),
        .MAX_LIFE       (MAX_LIFE),
        .SPEED_W        (8),
        .MIN_SPEED      (MIN_SPEED),
        .MAX_SPEED      (MAX_SPEED),
        .SPEED_STEP     (SPEED_STEP),
        .RESPAWN_FRAMES (RESPAWN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .startOfFrame  (startOfFrame),
        .key2IsPressed (key2IsPressed),
        .ballLost      (ballLost),
        .bonusLife     (bonusLife),
        .life          (life),
        .ballReady     (ballReady),
        .ballActive    (ballActive),
        .launch        (launch),
        .launchSpeed   (launchSpeed)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase name, frame counts, lives.
    string m_phase = "idle";
    int    m_life  = INIT_LIFE;
    int    m_speed = 0;
    int    m_frames = 0;
    int    m_rframes = 0;

    function automatic int bump(input int l, input logic b);
`ifdef BONUS_LIFE_EN
        if (b) return (l + 1 > MAX_LIFE) ? MAX_LIFE : l + 1;
`endif
        return l;
    endfunction

    task automatic model_step(input logic st, sf, k, l, b);
        int nl;
        if (!st) begin
            m_phase = "idle";
            m_life  = INIT_LIFE;
            return;
        end
        case (m_phase)
            "idle": begin
                m_life  = INIT_LIFE;
                m_phase = "park";
            end
            "park": begin
                m_life = bump(m_life, b);
                if (k) begin
                    m_phase  = "charge";
                    m_frames = 0;
                    m_speed  = MIN_SPEED;
                end
            end
            "charge": begin
                m_life = bump(m_life, b);
                if (k) begin
                    if (sf) m_frames++;
                    m_speed = MIN_SPEED + SPEED_STEP * m_frames;
                    if (m_speed > MAX_SPEED) m_speed = MAX_SPEED;
                end else begin
                    m_phase = "fire";
                end
            end
            "fire": begin
                m_life  = bump(m_life, b);
                m_phase = "flight";
            end
            "flight": begin
                nl = bump(m_life, b);
                if (l) begin
                    nl = nl - 1;
                    if (nl == 0) m_phase = "over";
                    else begin
                        m_phase   = "respawn";
                        m_rframes = 0;
                    end
                end
                m_life = nl;
            end
            "respawn": begin
                m_life = bump(m_life, b);
                if (sf) begin
                    m_rframes++;
                    if (m_rframes == RESPAWN) m_phase = "park";
                end
            end
            default: ;
        endcase
    endtask

    // Continuous compare against the model once out of reset.
    always @(negedge clk) begin
        if (!reset) begin
            check("life", int'(life), m_life);
            check("ballReady", int'(ballReady),
                  int'(m_phase == "park" || m_phase == "charge"));
            check("ballActive", int'(ballActive), int'(m_phase == "flight"));
            check("launch", int'(launch), int'(m_phase == "fire"));
            check("launchSpeed", int'(launchSpeed), m_speed);
        end
    end

    task automatic tick(input logic st, sf, k, l, b);
        start         = st;
        startOfFrame  = sf;
        key2IsPressed = k;
        ballLost      = l;
        bonusLife     = b;
        @(posedge clk);
        model_step(st, sf, k, l, b);
        #1;
        startOfFrame = 1'b0;
        ballLost     = 1'b0;
        bonusLife    = 1'b0;
    endtask

    // From PARK: press, charge over n frames, release; ends in FIRE.
    task automatic charge_release(input int n);
        tick(1, 0, 1, 0, 0);
        for (int i = 0; i < n; i++) begin
            tick(1, 0, 1, 0, 0);
            tick(1, 1, 1, 0, 0);
        end
        tick(1, 0, 0, 0, 0);
    endtask

    // From RESPAWN: let all respawn frames elapse; ends in PARK.
    task automatic respawn_wait();
        for (int i = 0; i < RESPAWN; i++) begin
            tick(1, 0, 0, 0, 0);
            tick(1, 1, 0, 0, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        startOfFrame = 1'b0;
        key2IsPressed = 1'b0;
        ballLost = 1'b0;
        bonusLife = 1'b0;
        #3;
        check("rst_life", int'(life), 3);
        check("rst_speed", int'(launchSpeed), 0);
        check("rst_flags", int'({ballReady, ballActive, launch}), 0);
        #9 reset = 1'b0;

        // Start -> park
        tick(1, 0, 0, 0, 0);
        check("park_ready", int'(ballReady), 1);
        check("park_life", int'(life), 3);
        check("park_launch", int'(launch), 0);

        // Ten frames of charge
        charge_release(10);
        check("fire_launch", int'(launch), 1);
        check("fire_speed", int'(launchSpeed), 56);
        tick(1, 0, 0, 0, 0);
        check("flight_active", int'(ballActive), 1);
        check("flight_launch", int'(launch), 0);
        check("flight_speed_held", int'(launchSpeed), 56);

        // First loss
        tick(1, 0, 0, 1, 0);
        check("loss1_life", int'(life), 2);
        check("loss1_active", int'(ballActive), 0);
        respawn_wait();
        check("respawn1_ready", int'(ballReady), 1);

        // Long charge saturates
        charge_release(60);
        check("sat_speed", int'(launchSpeed), 200);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 0);
        check("loss2_life", int'(life), 1);
        respawn_wait();

        // Tap with no frames: minimum speed
        charge_release(0);
        check("tap_speed", int'(launchSpeed), 16);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 0);
        check("over_life", int'(life), 0);
        check("over_flags", int'({ballReady, ballActive, launch}), 0);
        for (int i = 0; i < 3; i++) tick(1, 1, 1, 1, 0);
        check("over_hold_life", int'(life), 0);
        tick(0, 0, 0, 0, 0);
        check("idle_life", int'(life), 3);

        // Abort during charge with a simultaneous loss
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 0);
        tick(1, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 0);
        check("abort_life", int'(life), 3);
        check("abort_flags", int'({ballReady, ballActive, launch}), 0);
        tick(0, 0, 0, 0, 0);
        check("abort_no_launch", int'(launch), 0);

        // Bring life down to 1 in flight, then bonus + loss together
        tick(1, 0, 0, 0, 0);
        charge_release(2);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 0);
        respawn_wait();
        charge_release(1);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 0);
        respawn_wait();
        charge_release(1);
        tick(1, 0, 0, 0, 0);
        check("pre_bonus_life", int'(life), 1);
        tick(1, 0, 0, 1, 1);
`ifdef BONUS_LIFE_EN
        check("bonus_loss_life", int'(life), 1);
        check("bonus_loss_active", int'(ballActive), 0);
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 0, 1);
        check("bonus_sat_life", int'(life), 9);
        tick(1, 0, 0, 0, 1);
        check("bonus_sat_again", int'(life), 9);
`else
        check("nobonus_loss_life", int'(life), 0);
        check("nobonus_flags", int'({ballReady, ballActive, launch}), 0);
`endif
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
